// File: rtl/decode_stage.sv
// Instruction-decode stage: field decode, 32x32 register file with write-back
// bypass, A/B operand select, RAW hazard stall and the pipeline register to execute.
module decode_stage #(
  parameter int DATA_BITS             = 32,
  parameter int reg_addr_width        = 5,
  parameter int PROGRAM_COUNTER_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [31:0]                      instr,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc_in,
  input  logic                             flush,
  input  logic                             wb_RW,
  input  logic [reg_addr_width-1:0]        wb_DA,
  input  logic [DATA_BITS-1:0]             wb_data,
  output logic                             stall,
  output logic                             RW,
  output logic                             MW,
  output logic                             PS,
  output logic [reg_addr_width-1:0]        DA,
  output logic [1:0]                       MD,
  output logic [1:0]                       BS,
  output logic [3:0]                       FS,
  output logic [reg_addr_width-1:0]        SH,
  output logic [DATA_BITS-1:0]             BUSA,
  output logic [DATA_BITS-1:0]             BUSB,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] pc_min_two
);

  localparam int NREGS = 1 << reg_addr_width;

  localparam logic [6:0] OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_SUB = 7'b0000101;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR  = 7'b0001001;
  localparam logic [6:0] OP_XOR = 7'b0001010;
  localparam logic [6:0] OP_LSR = 7'b0001101;
  localparam logic [6:0] OP_LSL = 7'b0001110;
  localparam logic [6:0] OP_LD  = 7'b0010000;
  localparam logic [6:0] OP_ST  = 7'b0100000;
  localparam logic [6:0] OP_ADI = 7'b0100010;
  localparam logic [6:0] OP_SLT = 7'b1100101;
  localparam logic [6:0] OP_BZ  = 7'b1100000;
  localparam logic [6:0] OP_BNZ = 7'b1001000;
  localparam logic [6:0] OP_JMP = 7'b1110000;
  localparam logic [6:0] OP_JML = 7'b0110000;

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [3:0] fs;
    logic       mb;
    logic       ma;
    logic       cs;
  } ctrl_t;

  logic [6:0]                op;
  logic [reg_addr_width-1:0] dr;
  logic [reg_addr_width-1:0] sa;
  logic [reg_addr_width-1:0] sb;
  logic [reg_addr_width-1:0] shamt;
  logic [14:0]               im;

  assign op    = instr[31:25];
  assign dr    = instr[20 +: reg_addr_width];
  assign sa    = instr[15 +: reg_addr_width];
  assign sb    = instr[10 +: reg_addr_width];
  assign shamt = instr[0 +: reg_addr_width];
  assign im    = instr[14:0];

  ctrl_t ctrl;

  // Control word layout: rw md bs ps mw fs mb ma cs; unknown opcodes fall to NOP.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD: ctrl = ctrl_t'(14'b1_00_00_0_0_0010_0_0_0);
      OP_SUB: ctrl = ctrl_t'(14'b1_00_00_0_0_0101_0_0_0);
      OP_AND: ctrl = ctrl_t'(14'b1_00_00_0_0_1000_0_0_0);
      OP_OR:  ctrl = ctrl_t'(14'b1_00_00_0_0_1001_0_0_0);
      OP_XOR: ctrl = ctrl_t'(14'b1_00_00_0_0_1010_0_0_0);
      OP_LSR: ctrl = ctrl_t'(14'b1_00_00_0_0_1101_0_0_0);
      OP_LSL: ctrl = ctrl_t'(14'b1_00_00_0_0_1110_0_0_0);
      OP_LD:  ctrl = ctrl_t'(14'b1_01_00_0_0_0000_0_0_0);
      OP_ST:  ctrl = ctrl_t'(14'b0_00_00_0_1_0000_0_0_0);
      OP_ADI: ctrl = ctrl_t'(14'b1_00_00_0_0_0010_1_0_1);
      OP_SLT: ctrl = ctrl_t'(14'b1_10_00_0_0_0101_0_0_0);
      OP_BZ:  ctrl = ctrl_t'(14'b0_00_01_0_0_0000_1_0_1);
      OP_BNZ: ctrl = ctrl_t'(14'b0_00_01_1_0_0000_1_0_1);
      OP_JMP: ctrl = ctrl_t'(14'b0_00_11_0_0_0000_1_0_1);
      OP_JML: ctrl = ctrl_t'(14'b1_00_11_0_0_0111_1_1_1);
      default: ctrl = '0;
    endcase
  end

  // Register file; entry 0 is never written and always reads as zero.
  logic [DATA_BITS-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_RW && wb_DA != '0) begin
      regs[wb_DA] <= wb_data;
    end
  end

  logic [DATA_BITS-1:0] rd_a;
  logic [DATA_BITS-1:0] rd_b;
  logic                 byp_a;
  logic                 byp_b;

  // A write landing this cycle is forwarded so the reader never sees stale data.
  assign byp_a = wb_RW && (wb_DA != '0) && (wb_DA == sa);
  assign byp_b = wb_RW && (wb_DA != '0) && (wb_DA == sb);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (sa != '0) rd_a = byp_a ? wb_data : regs[sa];
    if (sb != '0) rd_b = byp_b ? wb_data : regs[sb];
  end

  logic [DATA_BITS-1:0] konst;
  logic [DATA_BITS-1:0] busa_next;
  logic [DATA_BITS-1:0] busb_next;

  assign konst     = ctrl.cs ? {{(DATA_BITS-15){im[14]}}, im}
                             : {{(DATA_BITS-15){1'b0}}, im};
  assign busa_next = ctrl.ma ? DATA_BITS'(pc_in) : rd_a;
  assign busb_next = ctrl.mb ? konst : rd_b;

  logic reads_a;
  logic reads_b;
  logic hazard;

  assign reads_a = !ctrl.ma;
  assign reads_b = !ctrl.mb;
  assign hazard  = RW && (DA != '0) &&
                   ((reads_a && sa == DA) || (reads_b && sb == DA));

  // stall is a hold request to fetch: while high, fetch keeps instr/pc_in unchanged
  // and this stage issues a bubble; it drops the next cycle once the producer
  // has moved on to write-back and the bypass supplies its result.
  assign stall = !flush && hazard;

  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall) begin
      RW         <= 1'b0;
      MW         <= 1'b0;
      PS         <= 1'b0;
      DA         <= '0;
      MD         <= '0;
      BS         <= '0;
      FS         <= '0;
      SH         <= '0;
      BUSA       <= '0;
      BUSB       <= '0;
      pc_min_two <= '0;
    end else begin
      RW         <= ctrl.rw;
      MW         <= ctrl.mw;
      PS         <= ctrl.ps;
      DA         <= dr;
      MD         <= ctrl.md;
      BS         <= ctrl.bs;
      FS         <= ctrl.fs;
      SH         <= shamt;
      BUSA       <= busa_next;
      BUSB       <= busb_next;
      pc_min_two <= pc_in;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a table-driven
// behavioural model of decode, register file, bypass and hazard rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        wb_RW;
  logic [4:0]  wb_DA;
  logic [31:0] wb_data;
  logic        stall;
  logic        RW, MW, PS;
  logic [4:0]  DA;
  logic [1:0]  MD, BS;
  logic [3:0]  FS;
  logic [4:0]  SH;
  logic [31:0] BUSA, BUSB, pc_min_two;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc_in(pc_in), .flush(flush),
    .wb_RW(wb_RW), .wb_DA(wb_DA), .wb_data(wb_data), .stall(stall),
    .RW(RW), .MW(MW), .PS(PS), .DA(DA), .MD(MD), .BS(BS), .FS(FS), .SH(SH),
    .BUSA(BUSA), .BUSB(BUSB), .pc_min_two(pc_min_two)
  );

  always #5 clk = ~clk;

  localparam int BW = 117;
  logic [BW-1:0] dut_bundle;
  assign dut_bundle = {RW, MW, PS, DA, MD, BS, FS, SH, BUSA, BUSB, pc_min_two};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Each entry: opcode[20:14], then rw md bs ps mw fs mb ma cs.
  logic [20:0] dec_tbl [16];
  logic [31:0] m_regs [32];
  logic        m_rw, m_da_nz;
  logic [4:0]  m_da;
  logic        nx_rw;
  logic [4:0]  nx_da;
  logic        exp_stall;
  logic        obs_stall;

  function automatic logic [13:0] lookup(input logic [6:0] op);
    logic [13:0] c = '0;
    for (int k = 0; k < 16; k++) if (dec_tbl[k][20:14] == op) c = dec_tbl[k][13:0];
    return c;
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_RW && wb_DA == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic model_eval(output logic [BW-1:0] nx);
    logic [13:0] c;
    logic [4:0]  sa, sb;
    logic [31:0] k, ba, bb;
    logic        rd_a, rd_b;
    c    = lookup(instr[31:25]);
    sa   = instr[19:15];
    sb   = instr[14:10];
    k    = c[0] ? 32'($signed(instr[14:0])) : {17'h0, instr[14:0]};
    ba   = c[1] ? pc_in : read_reg(sa);
    bb   = c[2] ? k : read_reg(sb);
    rd_a = !c[1];
    rd_b = !c[2];
    exp_stall = !flush && m_rw && (m_da != 0) &&
                ((rd_a && sa == m_da) || (rd_b && sb == m_da));
    if (!rst_n || flush || exp_stall) nx = '0;
    else nx = {c[13], c[7], c[8], instr[24:20], c[12:11], c[10:9], c[6:3],
               instr[4:0], ba, bb, pc_in};
    nx_rw = nx[116];
    nx_da = nx[113:109];
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    end else if (wb_RW && wb_DA != 0) begin
      m_regs[wb_DA] = wb_data;
    end
    m_rw = nx_rw;
    m_da = nx_da;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic f,
                      input logic wrw, input logic [4:0] wda, input logic [31:0] wd,
                      input logic rn);
    logic [BW-1:0] nx;
    instr = i; pc_in = p; flush = f; wb_RW = wrw; wb_DA = wda; wb_data = wd; rst_n = rn;
    @(negedge clk);
    model_eval(nx);
    obs_stall = stall;
    check("stall", 128'(stall), 128'(exp_stall));
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    model_commit();
    check("bundle", 128'(dut_bundle), 128'(exp_q.pop_front()));
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] dr,
                                     input logic [4:0] sa, input logic [4:0] sb);
    return {op, dr, sa, sb, 10'h0};
  endfunction

  function automatic logic [31:0] mki(input logic [6:0] op, input logic [4:0] dr,
                                      input logic [4:0] sa, input logic [14:0] im);
    return {op, dr, sa, im};
  endfunction

  localparam logic [6:0] ADD = 7'b0000010, SUB = 7'b0000101, ST = 7'b0100000,
                         ADI = 7'b0100010, JML = 7'b0110000;

  initial begin
    dec_tbl = '{
      {7'b0000000, 14'b0_00_00_0_0_0000_0_0_0}, {7'b0000010, 14'b1_00_00_0_0_0010_0_0_0},
      {7'b0000101, 14'b1_00_00_0_0_0101_0_0_0}, {7'b0001000, 14'b1_00_00_0_0_1000_0_0_0},
      {7'b0001001, 14'b1_00_00_0_0_1001_0_0_0}, {7'b0001010, 14'b1_00_00_0_0_1010_0_0_0},
      {7'b0001101, 14'b1_00_00_0_0_1101_0_0_0}, {7'b0001110, 14'b1_00_00_0_0_1110_0_0_0},
      {7'b0010000, 14'b1_01_00_0_0_0000_0_0_0}, {7'b0100000, 14'b0_00_00_0_1_0000_0_0_0},
      {7'b0100010, 14'b1_00_00_0_0_0010_1_0_1}, {7'b1100101, 14'b1_10_00_0_0_0101_0_0_0},
      {7'b1100000, 14'b0_00_01_0_0_0000_1_0_1}, {7'b1001000, 14'b0_00_01_1_0_0000_1_0_1},
      {7'b1110000, 14'b0_00_11_0_0_0000_1_0_1}, {7'b0110000, 14'b1_00_11_0_0_0111_1_1_1}
    };
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_rw = 1'b0; m_da = '0; m_da_nz = 1'b0;

    // Reset held for two cycles
    rst_n = 1'b0; instr = '0; pc_in = '0; flush = 1'b0;
    wb_RW = 1'b0; wb_DA = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 128'(dut_bundle), 128'h0);
    check("reset_stall", 128'(stall), 128'h0);

    // Freshly reset registers read zero
    step(mk(ADD, 5'd1, 5'd7, 5'd9), 32'h4, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("rst_read_a", 128'(BUSA), 128'h0);
    check("rst_read_b", 128'(BUSB), 128'h0);

    // Same-cycle write-back bypass
    step(mk(ADD, 5'd1, 5'd3, 5'd3), 32'h8, 1'b0, 1'b1, 5'd3, 32'h12345678, 1'b1);
    check("byp_busa", 128'(BUSA), 128'h12345678);
    check("byp_busb", 128'(BUSB), 128'h12345678);
    check("byp_fs", 128'(FS), 128'h2);
    check("byp_rw", 128'(RW), 128'h1);
    check("byp_da", 128'(DA), 128'h1);

    // ADI sign extension, with a concurrent write to R0 that must be dropped
    step(mki(ADI, 5'd2, 5'd0, 15'h7fff), 32'hc, 1'b0, 1'b1, 5'd0, 32'hdeadbeef, 1'b1);
    check("adi_busb", 128'(BUSB), 128'hffffffff);
    step(mk(ADD, 5'd4, 5'd0, 5'd0), 32'h10, 1'b0, 1'b1, 5'd0, 32'hdeadbeef, 1'b1);
    check("r0_busa", 128'(BUSA), 128'h0);
    check("r0_busb", 128'(BUSB), 128'h0);

    // RAW hazard: one bubble, then the consumer issues with the bypassed value
    step(mk(ADD, 5'd5, 5'd1, 5'd1), 32'h14, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(mk(SUB, 5'd6, 5'd5, 5'd4), 32'h18, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("raw_stall", 128'(obs_stall), 128'h1);
    check("raw_bubble", 128'({RW, MW, BS}), 128'h0);
    step(mk(SUB, 5'd6, 5'd5, 5'd4), 32'h18, 1'b0, 1'b1, 5'd5, 32'hcafef00d, 1'b1);
    check("raw_release", 128'(obs_stall), 128'h0);
    check("raw_busa", 128'(BUSA), 128'hcafef00d);
    check("raw_fs", 128'(FS), 128'h5);
    check("raw_da", 128'(DA), 128'h6);

    // Flush overrides a pending hazard; flushed ST leaves nothing behind
    step(mk(ADD, 5'd7, 5'd6, 5'd6), 32'h1c, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check("flush_no_stall", 128'(obs_stall), 128'h0);
    check("flush_zero", 128'(dut_bundle), 128'h0);
    step(mk(ST, 5'd0, 5'd1, 5'd2), 32'h20, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check("flush_st_mw", 128'(MW), 128'h0);
    check("flush_st_zero", 128'(dut_bundle), 128'h0);

    // JML: PC on A, constant on B
    step(mki(JML, 5'd31, 5'd0, 15'h0010), 32'h40, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("jml_busa", 128'(BUSA), 128'h40);
    check("jml_busb", 128'(BUSB), 128'h10);
    check("jml_bs", 128'(BS), 128'h3);
    check("jml_rw", 128'(RW), 128'h1);
    check("jml_pc", 128'(pc_min_two), 128'h40);

    // Reset during a stall clears the hazard
    step(mk(ADD, 5'd9, 5'd1, 5'd1), 32'h44, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(mk(SUB, 5'd1, 5'd9, 5'd9), 32'h48, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(mk(SUB, 5'd1, 5'd9, 5'd9), 32'h48, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("rst_clears_hazard", 128'(obs_stall), 128'h0);

    // Randomized traffic; fetch holds its instruction while stalled
    begin
      logic [31:0] ri, rp;
      logic [6:0]  op;
      logic [4:0]  sb;
      ri = 32'h0;
      rp = 32'h100;
      for (int n = 0; n < 400; n++) begin
        if (!exp_stall) begin
          if ($urandom_range(0, 99) < 85) op = dec_tbl[$urandom_range(0, 15)][20:14];
          else op = 7'($urandom_range(0, 127));
          sb = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
          ri = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), sb, 10'($urandom)};
          rp = rp + 32'h4;
        end
        step(ri, rp, $urandom_range(0, 99) < 10, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 99) >= 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
